// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Two-port round-robin arbiter/sequencer for a single-port
//               asynchronous RAM. All RAM-side signals are registered.
//               Defining RAM_ARB_FIXED_PRIO_EN selects fixed priority
//               (port 0 wins ties) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_wr,
    output logic          ram_en,
    input  logic [DW-1:0] ram_data_out
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_winner;
    logic          w_winner;
    logic          w_pick1;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_done0;
    logic          w_done1;
    logic          w_ram_en;
    logic          w_ram_wr;
    logic [AW-1:0] w_ram_addr;
    logic [DW-1:0] w_ram_data_in;
    logic [DW-1:0] w_rdata;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign w_pick1 = req1 & ~req0;
`else
    logic r_last;
    logic w_last;

    // On a tie the port that was not served last wins (r_last=1: port 1).
    assign w_pick1 = req1 & (~req0 | ~r_last);
    assign w_last  = (r_state == c_ACCESS) ? r_winner : r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else begin
            r_last <= w_last;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (req0 | req1) w_state_nxt = c_ACCESS;
            c_ACCESS: w_state_nxt = c_DONE;
            c_DONE:   w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_gnt0        = 1'b0;
        w_gnt1        = 1'b0;
        w_done0       = 1'b0;
        w_done1       = 1'b0;
        w_ram_en      = 1'b0;
        w_ram_wr      = 1'b0;
        w_ram_addr    = ram_addr;
        w_ram_data_in = ram_data_in;
        w_rdata       = rdata;
        w_winner      = r_winner;
        case (r_state)
            c_IDLE: begin
                if (req0 | req1) begin
                    w_winner      = w_pick1;
                    w_ram_en      = 1'b1;
                    w_ram_wr      = w_pick1 ? wr1 : wr0;
                    w_ram_addr    = w_pick1 ? addr1 : addr0;
                    w_ram_data_in = w_pick1 ? wdata1 : wdata0;
                    w_gnt0        = ~w_pick1;
                    w_gnt1        = w_pick1;
                end
            end
            c_ACCESS: begin
                // RAM output is only valid here; the DONE cycle is turnaround.
                if (!ram_wr) w_rdata = ram_data_out;
                w_done0 = ~r_winner;
                w_done1 = r_winner;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            ram_en      <= 1'b0;
            ram_wr      <= 1'b0;
            ram_addr    <= '0;
            ram_data_in <= '0;
            rdata       <= '0;
            r_winner    <= 1'b0;
        end else begin
            gnt0        <= w_gnt0;
            gnt1        <= w_gnt1;
            done0       <= w_done0;
            done1       <= w_done1;
            ram_en      <= w_ram_en;
            ram_wr      <= w_ram_wr;
            ram_addr    <= w_ram_addr;
            ram_data_in <= w_ram_data_in;
            rdata       <= w_rdata;
            r_winner    <= w_winner;
        end
    end

endmodule
`default_nettype wire
